// File: rtl/mem_load_unit.sv
// MEM stage load unit: EMPTY/WAIT/DONE tracking, load data extraction, stale-response discard.
// Define MEM_LOAD_FWD_EN to enable the forwarding bundle; otherwise the fwd_* outputs are tied to 0.
module mem_load_unit #(
  parameter int DATA_W    = 32,
  parameter int OST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [31:0]       in_pc,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_is_load,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_sign,
  input  logic              in_req_sent,
  input  logic              resp_data_ok,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [31:0]       out_pc,
  output logic              out_rf_we,
  output logic [4:0]        out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  input  logic              flush,
  output logic              fwd_valid,
  output logic              fwd_ready,
  output logic [4:0]        fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata
);

  localparam int SH_W  = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(OST_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(OST_DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONES    = {DATA_W{1'b1}};

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  disc_q, disc_d;
  logic [31:0]       pc_q, pc_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_sign_q, ld_sign_d;

  logic              accept;
  logic              resp_hit;
  logic [1:0]        next_st;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] ld_result;
  logic              sign_bit;
  int unsigned       nbits;

  assign out_valid  = (state_q == S_DONE);
  assign in_allowin = ((state_q == S_EMPTY) | ((state_q == S_DONE) & out_allowin))
                      & (disc_q < DEPTH_C);
  assign accept     = in_valid & in_allowin & ~flush;
  assign resp_hit   = (state_q == S_WAIT) & resp_data_ok & (disc_q == '0);
  assign next_st    = (in_is_load & in_req_sent) ? S_WAIT : S_DONE;

  // While waiting, wdata_q still holds the address, so its low bits select the byte lane.
  always_comb begin
    shifted = resp_rdata >> {wdata_q[SH_W-1:0], 3'b000};
    case (ld_size_q)
      2'd0:    nbits = 8;
      2'd1:    nbits = 16;
      2'd2:    nbits = 32;
      default: nbits = DATA_W;
    endcase
    mask      = ONES >> (DATA_W - nbits);
    sign_bit  = |(shifted & (mask ^ (mask >> 1)));
    ld_result = (shifted & mask) | ((ld_sign_q & sign_bit) ? ~mask : '0);
  end

  always_comb begin
    state_d    = state_q;
    disc_d     = disc_q;
    pc_d       = pc_q;
    rf_we_d    = rf_we_q;
    rf_waddr_d = rf_waddr_q;
    wdata_d    = wdata_q;
    ld_size_d  = ld_size_q;
    ld_sign_d  = ld_sign_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = next_st;
        S_WAIT:  if (resp_hit) state_d = S_DONE;
        S_DONE:  if (out_allowin) state_d = accept ? next_st : S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end

    // A flushed WAIT leaves its own response outstanding unless it arrives this very cycle.
    if (resp_data_ok && (disc_q != '0))
      disc_d = disc_q - ONE_C;
    if (flush && (state_q == S_WAIT) && !resp_hit)
      disc_d = disc_d + ONE_C;

    if (accept) begin
      pc_d       = in_pc;
      rf_we_d    = in_rf_we;
      rf_waddr_d = in_rf_waddr;
      wdata_d    = in_alu_result;
      ld_size_d  = in_ld_size;
      ld_sign_d  = in_ld_sign;
    end else if (resp_hit && !flush) begin
      wdata_d = ld_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    rf_we_q    <= rf_we_d;
    rf_waddr_q <= rf_waddr_d;
    wdata_q    <= wdata_d;
    ld_size_q  <= ld_size_d;
    ld_sign_q  <= ld_sign_d;
  end

  assign out_pc       = pc_q;
  assign out_rf_we    = rf_we_q;
  assign out_rf_waddr = rf_waddr_q;
  assign out_rf_wdata = wdata_q;

`ifdef MEM_LOAD_FWD_EN
  assign fwd_valid = ((state_q == S_WAIT) | (state_q == S_DONE)) & rf_we_q;
  assign fwd_ready = (state_q == S_DONE);
  assign fwd_waddr = rf_waddr_q;
  assign fwd_wdata = wdata_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_ready = 1'b0;
  assign fwd_waddr = '0;
  assign fwd_wdata = '0;
`endif

endmodule
